// File: rtl/sdram_pkg.sv
// Shared SDRAM command types used by the scheduler and its interface.
package sdram_pkg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_refresh_scheduler_if.sv
// Command-stream and refresh handshake bundle around the refresh scheduler.
// master = the scheduler, slave = the FIFO/controller environment.
interface sdram_refresh_scheduler_if;

  logic                  in_valid;
  logic                  in_ready;
  sdram_pkg::sdram_cmd_t in_data;
  logic                  out_valid;
  logic                  out_ready;
  sdram_pkg::sdram_cmd_t out_data;
  logic                  ref_req;
  logic                  ref_ack;

  modport master (
    input  in_valid, in_data, out_ready, ref_ack,
    output in_ready, out_valid, out_data, ref_req
  );

  modport slave (
    output in_valid, in_data, out_ready, ref_ack,
    input  in_ready, out_valid, out_data, ref_req
  );

endinterface

// File: rtl/sdram_refresh_scheduler.sv
// SDRAM refresh scheduler: counts tREFI, tracks postponed refreshes and
// inserts AUTO REFRESH requests into a zero-latency command pass-through,
// either opportunistically when idle or forcibly once debt is saturated.
module sdram_refresh_scheduler #(
  parameter int TREFI_CYCLES = 781,
  parameter int MAX_POSTPONE = 8,
  localparam int DEBT_W = $clog2(MAX_POSTPONE + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        init_done,
  sdram_refresh_scheduler_if.master   bus,
  output logic [DEBT_W-1:0]           ref_debt,
  output logic                        err_overrun
);

  localparam int CNT_W = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TREFI_CYCLES - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_POSTPONE);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_PASS      = 2'd1,
    S_REF       = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              held_q;
  logic              tick;
  logic              ack_taken;
  logic              urgent;
  logic              gate;
  logic              held;

  assign tick      = (state_q != S_WAIT_INIT) && (cnt_q == CNT_LAST);
  assign ack_taken = (state_q == S_REF) && bus.ref_ack;
  assign urgent    = (ref_debt == DEBT_MAX);
  // A command already offered keeps its slot even once debt turns urgent,
  // so the gate only closes for fresh offers.
  assign gate      = !(urgent && !held_q);
  assign held      = bus.out_valid && !bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_WAIT_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic: refresh only when no command is stuck on the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_INIT: if (init_done) state_d = S_PASS;
      S_PASS: begin
        if (!held && (urgent || ((ref_debt != '0) && !bus.in_valid)))
          state_d = S_REF;
      end
      S_REF:       if (bus.ref_ack) state_d = S_PASS;
      default:     state_d = S_WAIT_INIT;
    endcase
  end

  // Output decode: pass-through gated by urgency, refresh request in S_REF.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ref_req   = 1'b0;
    bus.out_data  = bus.in_data;
    case (state_q)
      S_PASS: begin
        bus.out_valid = bus.in_valid && gate;
        bus.in_ready  = bus.out_ready && gate;
      end
      S_REF:   bus.ref_req = 1'b1;
      default: ;
    endcase
  end

  // Remember an offer that was not taken so it is never withdrawn next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) held_q <= 1'b0;
    else       held_q <= held;
  end

  // tREFI interval counter, idle until the controller has finished init.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        cnt_q <= '0;
    else if (state_q == S_WAIT_INIT)  cnt_q <= '0;
    else if (tick)                    cnt_q <= '0;
    else                              cnt_q <= cnt_q + CNT_W'(1);
  end

  // Refresh debt bookkeeping and sticky overrun flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_debt    <= '0;
      err_overrun <= 1'b0;
    end else if (tick && !ack_taken) begin
      if (ref_debt == DEBT_MAX) err_overrun <= 1'b1;
      else                      ref_debt    <= ref_debt + DEBT_W'(1);
    end else if (ack_taken && !tick && (ref_debt != '0)) begin
      ref_debt <= ref_debt - DEBT_W'(1);
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.ref_req && bus.out_valid));
  a_req_stable: assert property (@(posedge clk) disable iff (!rstn)
    (bus.ref_req && !bus.ref_ack) |=> bus.ref_req);
  a_debt_bound: assert property (@(posedge clk) disable iff (!rstn)
    ref_debt <= DEBT_MAX);

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Directed bench for sdram_refresh_scheduler with TREFI_CYCLES=16, MAX_POSTPONE=2.
// Edge numbers E<n> count rising edges after the one that leaves S_WAIT_INIT.
module tb_sdram_refresh_scheduler;

  logic       clk;
  logic       rstn;
  logic       init_done;
  logic [1:0] ref_debt;
  logic       err_overrun;
  int         n_chk;
  int         n_err;

  sdram_refresh_scheduler_if bus ();

  sdram_refresh_scheduler #(
    .TREFI_CYCLES (16),
    .MAX_POSTPONE (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .init_done   (init_done),
    .bus         (bus),
    .ref_debt    (ref_debt),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rstn          = 1'b0;
    init_done     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 19'h00123;
    bus.out_ready = 1'b1;
    bus.ref_ack   = 1'b0;

    // Reset state: everything quiet even with traffic offered.
    repeat (3) clk_step();
    chk("rst_ref_req",  32'(bus.ref_req),   0);
    chk("rst_debt",     32'(ref_debt),      0);
    chk("rst_err",      32'(err_overrun),   0);
    chk("rst_in_ready", 32'(bus.in_ready),  0);
    chk("rst_out_vld",  32'(bus.out_valid), 0);

    rstn = 1'b1;
    repeat (3) clk_step();
    chk("wait_in_ready", 32'(bus.in_ready),  0);
    chk("wait_out_vld",  32'(bus.out_valid), 0);

    // Test 1: init, idle refresh.
    bus.in_valid = 1'b0;
    init_done    = 1'b1;
    clk_step();                                   // E0 -> S_PASS
    init_done    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 19'h00155;
    #1;
    chk("pass_out_vld",  32'(bus.out_valid), 1);
    chk("pass_in_ready", 32'(bus.in_ready),  1);
    chk("pass_data",     32'(bus.out_data),  32'h155);
    bus.in_valid = 1'b0;
    repeat (15) clk_step();                       // E15
    chk("t1_debt_pre",  32'(ref_debt),    0);
    clk_step();                                   // E16 tick
    chk("t1_debt_tick", 32'(ref_debt),    1);
    chk("t1_req_tick",  32'(bus.ref_req), 0);
    clk_step();                                   // E17
    chk("t1_req_rise",  32'(bus.ref_req), 1);
    clk_step();
    chk("t1_req_hold1", 32'(bus.ref_req), 1);
    clk_step();                                   // E19
    chk("t1_req_hold2", 32'(bus.ref_req), 1);
    bus.ref_ack = 1'b1;
    clk_step();                                   // E20
    bus.ref_ack = 1'b0;
    chk("t1_debt_ack",  32'(ref_debt),    0);
    chk("t1_req_ack",   32'(bus.ref_req), 0);

    // Test 2: continuous traffic until debt saturates.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin            // E21..E48
      bus.in_valid = 1'b1;
      bus.in_data  = 19'(32'h100 + i);
      #1;
      chk("t2_in_ready", 32'(bus.in_ready), 1);
      chk("t2_data",     32'(bus.out_data), 32'h100 + i);
      clk_step();
    end
    #1;
    chk("t2_debt_urg",  32'(ref_debt),      2);
    chk("t2_in_rdy_urg",32'(bus.in_ready),  0);
    chk("t2_out_v_urg", 32'(bus.out_valid), 0);
    chk("t2_req_urg",   32'(bus.ref_req),   0);
    clk_step();                                   // E49
    chk("t2_req",       32'(bus.ref_req),   1);
    chk("t2_in_rdy_ref",32'(bus.in_ready),  0);
    bus.ref_ack = 1'b1;
    clk_step();                                   // E50
    bus.ref_ack = 1'b0;
    #1;
    chk("t2_debt_ack",  32'(ref_debt),     1);
    chk("t2_resume",    32'(bus.in_ready), 1);
    chk("t2_req_ack",   32'(bus.ref_req),  0);

    // Test 3: command held across the urgent point; stray ack in S_PASS ignored.
    for (int j = 0; j < 13; j++) begin            // E51..E63
      bus.in_data = 19'(32'h200 + j);
      bus.ref_ack = (j == 3);
      #1;
      chk("t3_in_ready", 32'(bus.in_ready), 1);
      chk("t3_debt",     32'(ref_debt),     1);
      clk_step();
    end
    bus.ref_ack   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = 19'h1ABCD;
    #1;
    chk("t3_offer",     32'(bus.out_valid), 1);
    chk("t3_offer_rdy", 32'(bus.in_ready),  0);
    clk_step();                                   // E64 tick -> urgent
    chk("t3_debt_urg",  32'(ref_debt),      2);
    for (int k = 0; k < 5; k++) begin             // E64..E68
      chk("t3_hold_vld",  32'(bus.out_valid), 1);
      chk("t3_hold_data", 32'(bus.out_data),  32'h1ABCD);
      chk("t3_hold_req",  32'(bus.ref_req),   0);
      if (k < 4) clk_step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_accept",    32'(bus.in_ready),  1);
    clk_step();                                   // E69
    chk("t3_req_after", 32'(bus.ref_req),   1);
    chk("t3_vld_after", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0;

    // Test 5: tick and ack coincide at debt 1.
    bus.ref_ack = 1'b1;
    clk_step();                                   // E70
    bus.ref_ack = 1'b0;
    chk("t5_debt_pre",  32'(ref_debt),    1);
    clk_step();                                   // E71
    chk("t5_req",       32'(bus.ref_req), 1);
    repeat (8) clk_step();                        // E79
    bus.ref_ack = 1'b1;
    clk_step();                                   // E80 tick + ack
    bus.ref_ack = 1'b0;
    chk("t5_debt_same", 32'(ref_debt),    1);
    chk("t5_no_err",    32'(err_overrun), 0);
    chk("t5_req_drop",  32'(bus.ref_req), 0);
    clk_step();                                   // E81
    chk("t5_req_again", 32'(bus.ref_req), 1);

    // Test 4: ack withheld through saturation and a further tick.
    repeat (14) clk_step();                       // E95
    chk("t4_debt1",     32'(ref_debt),    1);
    clk_step();                                   // E96
    chk("t4_debt2",     32'(ref_debt),    2);
    chk("t4_err_pre",   32'(err_overrun), 0);
    repeat (15) clk_step();                       // E111
    chk("t4_err_still0",32'(err_overrun), 0);
    clk_step();                                   // E112
    chk("t4_err_set",   32'(err_overrun), 1);
    chk("t4_debt_stay", 32'(ref_debt),    2);
    chk("t4_req_stay",  32'(bus.ref_req), 1);
    repeat (9) clk_step();                        // E121
    bus.ref_ack = 1'b1;
    clk_step();                                   // E122
    bus.ref_ack = 1'b0;
    chk("t4_debt_ack",  32'(ref_debt),    1);
    chk("t4_err_stick", 32'(err_overrun), 1);
    chk("t4_req_ack",   32'(bus.ref_req), 0);
    clk_step();                                   // E123
    chk("t6_req_pre",   32'(bus.ref_req), 1);

    // Test 6: reset during refresh.
    rstn = 1'b0;
    #1;
    chk("t6_req_rst",   32'(bus.ref_req),   0);
    chk("t6_debt_rst",  32'(ref_debt),      0);
    chk("t6_err_rst",   32'(err_overrun),   0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    init_done     = 1'b0;
    repeat (2) clk_step();
    rstn = 1'b1;
    repeat (3) clk_step();
    chk("t6_in_rdy_wait", 32'(bus.in_ready),  0);
    chk("t6_out_v_wait",  32'(bus.out_valid), 0);
    init_done = 1'b1;
    clk_step();
    chk("t6_in_rdy_init", 32'(bus.in_ready),  1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
